// File: rtl/yarvi_uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter with a TX FIFO behind a 16-byte register window.
// Define UART_TX_IRQ_EN to add the IEN register (offset 3) and the tx_irq output.
module yarvi_uart_tx_mmio #(
  parameter logic [31:0] BASE          = 32'h4000_1000,
  parameter int          DEPTH         = 8,
  parameter logic [15:0] DIVISOR_RESET = 16'd434
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        valid,
  input  logic [31:0] address,
  input  logic [2:0]  funct3,
  input  logic        writeenable,
  input  logic        readenable,
  input  logic [31:0] writedata,
  output logic        rd_valid,
  output logic [31:0] rd_data,
`ifdef UART_TX_IRQ_EN
  output logic        tx_irq,
`endif
  output logic        txd
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  localparam logic [1:0] OFF_TXDATA  = 2'd0;
  localparam logic [1:0] OFF_STATUS  = 2'd1;
  localparam logic [1:0] OFF_DIVISOR = 2'd2;
`ifdef UART_TX_IRQ_EN
  localparam logic [1:0] OFF_IEN     = 2'd3;
`endif

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  // Request protocol: valid is a single-cycle strobe with no ready; every hit is
  // accepted in the cycle it is presented, and a read hit answers with rd_valid
  // exactly one cycle later (writes take effect at the same edge).
  logic       hit, wr_hit, rd_hit;
  logic [1:0] offset;

  state_e        state_q, state_d;
  logic [15:0]   bitcnt_q, bitcnt_d;
  logic [2:0]    bitidx_q, bitidx_d;
  logic [7:0]    sh_q, sh_d;
  logic [15:0]   divisor_q, divisor_d;
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          rd_valid_q, rd_valid_d;
  logic [31:0]   rd_data_q, rd_data_d;
`ifdef UART_TX_IRQ_EN
  logic          ien_q, ien_d;
  logic          tx_irq_q, tx_irq_d;
`endif

  logic push_req, push_ok, pop, fifo_empty, fifo_full, busy, bit_end;
  logic unused_bits;

  assign unused_bits = ^{funct3[2], writedata[31:16]};

  assign hit    = valid && ((address & 32'hFFFF_FFF0) == BASE) &&
                  (funct3[1:0] == 2'd2) && (address[1:0] == 2'd0);
  assign wr_hit = hit && writeenable;
  assign rd_hit = hit && readenable;
  assign offset = address[3:2];

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == FULL_CNT);
  assign busy       = (state_q != IDLE);
  assign bit_end    = (bitcnt_q == 16'd0);

  // FIFO bookkeeping; a same-cycle pop never frees a slot for the push.
  always_comb begin
    push_req = wr_hit && (offset == OFF_TXDATA);
    push_ok  = push_req && (count_q < FULL_CNT);
    wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop};
  end

  always_comb begin
    divisor_d  = divisor_q;
    overflow_d = overflow_q;
    rd_valid_d = rd_hit;
    rd_data_d  = 32'd0;
`ifdef UART_TX_IRQ_EN
    ien_d      = ien_q;
    tx_irq_d   = ien_q && fifo_empty && (state_q == IDLE);
    if (wr_hit && (offset == OFF_IEN)) ien_d = writedata[0];
`endif
    if (wr_hit && (offset == OFF_DIVISOR))
      divisor_d = (writedata[15:0] == 16'd0) ? 16'd1 : writedata[15:0];
    if (rd_hit && (offset == OFF_STATUS)) overflow_d = 1'b0;
    if (push_req && !push_ok) overflow_d = 1'b1;
    // Read data comes from pre-write state, so a same-cycle write is not visible.
    if (rd_hit) begin
      case (offset)
        OFF_STATUS:  rd_data_d = {28'd0, busy, overflow_q, fifo_empty, fifo_full};
        OFF_DIVISOR: rd_data_d = {16'd0, divisor_q};
`ifdef UART_TX_IRQ_EN
        OFF_IEN:     rd_data_d = {31'd0, ien_q};
`endif
        default:     rd_data_d = 32'd0;
      endcase
    end
  end

  // Every bit lasts divisor clocks; the counter reloads from the live DIVISOR.
  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    bitidx_d = bitidx_q;
    sh_d     = sh_q;
    pop      = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop      = 1'b1;
          sh_d     = mem_q[rd_ptr_q];
          bitcnt_d = divisor_q - 16'd1;
          state_d  = START;
        end
      end
      START: begin
        if (bit_end) begin
          bitcnt_d = divisor_q - 16'd1;
          bitidx_d = 3'd0;
          state_d  = DATA;
        end else begin
          bitcnt_d = bitcnt_q - 16'd1;
        end
      end
      DATA: begin
        if (bit_end) begin
          bitcnt_d = divisor_q - 16'd1;
          sh_d     = {1'b0, sh_q[7:1]};
          bitidx_d = bitidx_q + 3'd1;
          if (bitidx_q == 3'd7) state_d = STOP;
        end else begin
          bitcnt_d = bitcnt_q - 16'd1;
        end
      end
      STOP: begin
        if (bit_end) state_d = IDLE;
        else bitcnt_d = bitcnt_q - 16'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Decoded from the async-reset state register, so reset forces the line idle at once.
  always_comb begin
    case (state_q)
      START:   txd = 1'b0;
      DATA:    txd = sh_q[0];
      default: txd = 1'b1;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      bitcnt_q   <= 16'd0;
      bitidx_q   <= 3'd0;
      sh_q       <= 8'd0;
      divisor_q  <= DIVISOR_RESET;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= 32'd0;
`ifdef UART_TX_IRQ_EN
      ien_q      <= 1'b0;
      tx_irq_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      bitcnt_q   <= bitcnt_d;
      bitidx_q   <= bitidx_d;
      sh_q       <= sh_d;
      divisor_q  <= divisor_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
`ifdef UART_TX_IRQ_EN
      ien_q      <= ien_d;
      tx_irq_q   <= tx_irq_d;
`endif
    end
  end

  // Storage needs no reset: entries are only read once count says they are valid.
  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wr_ptr_q] <= writedata[7:0];
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
`ifdef UART_TX_IRQ_EN
  assign tx_irq   = tx_irq_q;
`endif

endmodule

// File: tb/tb_yarvi_uart_tx_mmio.sv
// Directed bench for yarvi_uart_tx_mmio: register access, frame timing, FIFO overflow, reset.
// The IEN/tx_irq steps are compiled only when UART_TX_IRQ_EN is defined.
module tb_yarvi_uart_tx_mmio;

  localparam logic [31:0] A_TXDATA = 32'h4000_1000;
  localparam logic [31:0] A_STATUS = 32'h4000_1004;
  localparam logic [31:0] A_DIV    = 32'h4000_1008;
  localparam logic [31:0] A_IEN    = 32'h4000_100C;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        valid = 1'b0;
  logic [31:0] address = 32'd0;
  logic [2:0]  funct3 = 3'd0;
  logic        writeenable = 1'b0;
  logic        readenable = 1'b0;
  logic [31:0] writedata = 32'd0;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        txd;
`ifdef UART_TX_IRQ_EN
  logic        tx_irq;
`endif

  int          n_vec = 0;
  int          n_err = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  pat [9];
  logic [7:0]  eb;
  logic        rv;
  logic [31:0] rdat;

  yarvi_uart_tx_mmio dut (
    .clock       (clock),
    .reset       (reset),
    .valid       (valid),
    .address     (address),
    .funct3      (funct3),
    .writeenable (writeenable),
    .readenable  (readenable),
    .writedata   (writedata),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
`ifdef UART_TX_IRQ_EN
    .tx_irq      (tx_irq),
`endif
    .txd         (txd)
  );

  // Clock and stepping: stimulus changes and sampling happen 1 time unit after posedge.
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp_v);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp_v);
    end
  endtask

  // Driver: one request cycle; returns the registered read response.
  task automatic bus(input logic [31:0] addr, input logic [2:0] f3, input logic we,
                     input logic re, input logic [31:0] wd,
                     output logic v, output logic [31:0] d);
    valid       = 1'b1;
    address     = addr;
    funct3      = f3;
    writeenable = we;
    readenable  = re;
    writedata   = wd;
    tick();
    v           = rd_valid;
    d           = rd_data;
    valid       = 1'b0;
    writeenable = 1'b0;
    readenable  = 1'b0;
  endtask

  task automatic rd(input logic [31:0] addr);
    bus(addr, 3'd2, 1'b0, 1'b1, 32'd0, rv, rdat);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    bus(addr, 3'd2, 1'b1, 1'b0, data, rv, rdat);
  endtask

  // Checks start bit, 8 data bits LSB first and stop bit, div clocks each.
  task automatic chk_frame(input logic [7:0] b, input int div);
    logic [9:0] fr;
    fr = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      for (int c = 0; c < div; c++) begin
        chk1($sformatf("frame %02h bit%0d clk%0d", b, i, c), txd, fr[i]);
        tick();
      end
    end
  endtask

  initial begin
    pat[0] = 8'h01; pat[1] = 8'h80; pat[2] = 8'hFF; pat[3] = 8'h00; pat[4] = 8'h55;
    pat[5] = 8'hAA; pat[6] = 8'h3C; pat[7] = 8'hC3; pat[8] = 8'h99;

    // Reset state
    tick(); tick();
    reset = 1'b0;
    chk1("reset txd", txd, 1'b1);
    chk1("reset rd_valid", rd_valid, 1'b0);
    chk("reset rd_data", rd_data, 32'd0);
    rd(A_STATUS);
    chk1("status after reset valid", rv, 1'b1);
    chk("status after reset", rdat, 32'h2);
    chk1("txd idle after reset", txd, 1'b1);
    tick();
    chk1("rd_valid one cycle only", rd_valid, 1'b0);
    chk("rd_data zero when not valid", rd_data, 32'd0);
    rd(A_DIV);
    chk("divisor reset value", rdat, 32'd434);

    // Single frame, DIVISOR=4, byte A5
    wr(A_DIV, 32'd4);
    wr(A_TXDATA, 32'h1A5);
    chk1("idle clock before start", txd, 1'b1);
    tick();
    chk_frame(8'hA5, 4);
    chk1("idle after frame", txd, 1'b1);
    rd(A_STATUS);
    chk("status after frame", rdat, 32'h2);

    // Busy flag: queued-but-not-popped, then mid-frame, then last stop clock, then idle
    wr(A_TXDATA, 32'h3C);
    rd(A_STATUS);
    chk("status byte queued", rdat, 32'h0);
    rd(A_STATUS);
    chk("status busy in frame", rdat, 32'hA);
    for (int i = 0; i < 38; i++) tick();
    chk1("stop bit late", txd, 1'b1);
    rd(A_STATUS);
    chk("status busy last stop clock", rdat, 32'hA);
    rd(A_STATUS);
    chk("status idle after stop", rdat, 32'h2);

    // Overflow: FSM holds a byte while 9 more are pushed back to back
    wr(A_DIV, 32'd2);
    wr(A_TXDATA, 32'hE7);
    tick();
    for (int k = 0; k < 9; k++) begin
      wr(A_TXDATA, {24'd0, pat[k]});
      if (k < 8) exp_q.push_back(pat[k]);
    end
    rd(A_STATUS);
    chk("status full+overflow", rdat, 32'hD);
    rd(A_STATUS);
    chk("status overflow cleared", rdat, 32'h9);
    for (int i = 0; i < 9; i++) tick();
    chk1("idle after held byte", txd, 1'b1);
    for (int k = 0; k < 8; k++) begin
      tick();
      eb = exp_q.pop_front();
      chk_frame(eb, 2);
      chk1($sformatf("single idle after frame %0d", k), txd, 1'b1);
    end
    tick(); tick();
    chk1("no ninth frame", txd, 1'b1);
    rd(A_STATUS);
    chk("status drained", rdat, 32'h2);

    // Decode boundaries and register corner cases
    wr(A_DIV, 32'd0);
    rd(A_DIV);
    chk("divisor zero stores one", rdat, 32'h1);
    bus(A_TXDATA, 3'd0, 1'b1, 1'b0, 32'h77, rv, rdat);
    rd(A_STATUS);
    chk("byte store no push", rdat, 32'h2);
    chk1("txd idle after byte store", txd, 1'b1);
    rd(32'h4000_0010);
    chk1("out of window rd_valid", rv, 1'b0);
    chk("out of window rd_data", rdat, 32'd0);
    rd(32'h4000_1005);
    chk1("misaligned rd_valid", rv, 1'b0);
    rd(A_TXDATA);
    chk1("txdata read valid", rv, 1'b1);
    chk("txdata read zero", rdat, 32'd0);
`ifndef UART_TX_IRQ_EN
    wr(A_IEN, 32'h1);
    rd(A_IEN);
    chk1("offset3 read valid", rv, 1'b1);
    chk("offset3 reads zero", rdat, 32'd0);
`endif
    bus(A_DIV, 3'd2, 1'b1, 1'b1, 32'd7, rv, rdat);
    chk("read+write returns old", rdat, 32'h1);
    rd(A_DIV);
    chk("read+write stored new", rdat, 32'h7);

    // Reset asserted in the middle of a data bit
    wr(A_DIV, 32'd4);
    wr(A_TXDATA, 32'h00);
    for (int i = 0; i < 6; i++) tick();
    chk1("txd low in data bit", txd, 1'b0);
    reset = 1'b1;
    #1;
    chk1("txd high on async reset", txd, 1'b1);
    @(posedge clock);
    #1;
    reset = 1'b0;
    chk1("txd idle after reset", txd, 1'b1);
    rd(A_STATUS);
    chk("status after mid-frame reset", rdat, 32'h2);
    rd(A_DIV);
    chk("divisor restored", rdat, 32'd434);

`ifdef UART_TX_IRQ_EN
    // Interrupt: empty-and-idle, registered one cycle
    wr(A_DIV, 32'd2);
    chk1("irq off at reset", tx_irq, 1'b0);
    wr(A_IEN, 32'h1);
    chk1("irq not yet", tx_irq, 1'b0);
    tick();
    chk1("irq after ien", tx_irq, 1'b1);
    rd(A_IEN);
    chk("ien readback", rdat, 32'h1);
    wr(A_TXDATA, 32'h5A);
    chk1("irq before pop", tx_irq, 1'b1);
    for (int i = 1; i <= 21; i++) begin
      tick();
      chk1($sformatf("irq low in frame %0d", i), tx_irq, 1'b0);
    end
    tick();
    chk1("irq after stop", tx_irq, 1'b1);
`endif

    // Report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/yarvi_uart_tx_mmio.md
Name: yarvi_uart_tx_mmio

Overview:
- Memory-mapped UART transmitter that responds to the load/store unit's request stream for one 16-byte register window.
- Accepts word stores to push bytes into a TX FIFO, serialises them 8N1 on `txd`, and returns word loads one cycle later, with the same timing as a data-memory load.
- Sits beside the timer MMIO block on the ME request bus; its read data is muxed into the ME load path.

Parameters:
- BASE, 32'h40001000, window base address; 16-byte aligned.
- DEPTH, 8, TX FIFO entries; power of two, at least 2.
- DIVISOR_RESET, 434, reset value of DIVISOR (clocks per bit).

Ports:
- clock  in  1  single clock; all logic on posedge.
- reset  in  1  asynchronous, active-high; clears all state.
- valid  in  1  request strobe from ME.
- address  in  32  byte address of the request.
- funct3  in  3  access size; only word (funct3[1:0]==2) is honoured.
- writeenable  in  1  store request.
- readenable  in  1  load request.
- writedata  in  32  store data.
- rd_valid  out  1  registered; high the cycle after an accepted read hit.
- rd_data  out  32  registered read data; 0 when rd_valid is low.
- txd  out  1  serial output; idle high.

Behaviour:
- Hit: `valid & ((address & 32'hFFFFFFF0) == BASE) & (funct3[1:0]==2) & (address[1:0]==0)`. Non-hits and non-word accesses have no effect and give rd_valid=0.
- Register map (offset = address[3:2]):
  - 0 TXDATA. Write pushes writedata[7:0]. Read returns 0.
  - 1 STATUS, read-only: bit0 full, bit1 fifo_empty, bit2 overflow (sticky), bit3 busy (FSM not IDLE), other bits 0.
  - 2 DIVISOR[15:0]. Read/write; bits 31:16 read 0. Writing 0 stores 1.
  - 3 see optional feature.
- Read latency: 1 cycle. rd_data is sampled from the register state before any same-cycle write takes effect. A read of STATUS clears overflow at the end of that cycle; the returned value still shows the old overflow.
- A request with both readenable and writeenable does the write and the read.
- FIFO:
  - Push is accepted iff count<DEPTH at the start of the cycle; a same-cycle pop does not free a slot.
  - A rejected push sets overflow and leaves the data unchanged.
  - Push and pop in the same cycle leave count unchanged.
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH; count is log2(DEPTH)+1 bits.
- TX FSM, states IDLE, START, DATA, STOP:
  - IDLE: txd=1. If FIFO non-empty, pop the head into shift register sh, load bitcnt=DIVISOR-1, go to START.
  - START: txd=0.
  - DATA: txd=sh[0], 8 bits LSB first.
  - STOP: txd=1.
  - Each bit lasts exactly DIVISOR clocks. bitcnt decrements; at 0 the bit ends and bitcnt reloads from the current DIVISOR. A DIVISOR write mid-frame therefore applies from the next bit.
  - After STOP, return to IDLE. Back-to-back frames cost exactly one extra IDLE clock between stop bit and start bit.
- Reset values: txd=1, rd_valid=0, rd_data=0, FSM IDLE, FIFO empty, overflow=0, DIVISOR=DIVISOR_RESET.
- Reset mid-frame aborts the frame and drives txd=1 asynchronously.
- Reads of offsets with no function return 0 with rd_valid=1.

Optional Feature:
- Macro: UART_TX_IRQ_EN.
- Defined:
  - Adds output port `tx_irq` (1 bit, registered, reset 0).
  - Offset 3 becomes IEN, bit0 read/write, reset 0.
  - tx_irq = IEN[0] & fifo_empty & FSM IDLE, registered one cycle.
- Not defined:
  - No `tx_irq` port.
  - Offset 3 reads 0; writes to it are ignored.

Test Plan:
- Reset, then read STATUS (40001004) -> next cycle rd_valid=1, rd_data=32'h2; txd=1 throughout.
- Write DIVISOR=4, then write TXDATA 32'h1A5 -> txd: 1 IDLE clock, then 0 for 4 clocks, then bits 1,0,1,0,0,1,0,1 at 4 clocks each, then 1 for 4 clocks. STATUS busy=1 during the frame, 0 after.
- With DIVISOR=2, push DEPTH+1=9 bytes in consecutive cycles while the FSM holds the first byte:
  - the 9th push is dropped;
  - first STATUS read returns overflow bit2=1, the second returns bit2=0;
  - the bytes transmitted match pushes 1-8 in order;
  - the frames are separated by exactly one idle clock.
- Write DIVISOR=0, read DIVISOR -> 32'h1. Byte store (funct3=0) to TXDATA -> no push (fifo_empty stays 1). Read of 40000010 -> rd_valid=0.
- Assert reset for 1 cycle mid-DATA bit -> txd=1 immediately, STATUS=32'h2 afterwards, DIVISOR=434.
- With UART_TX_IRQ_EN defined: write IEN=1 with the FIFO empty -> tx_irq=1 after 1 cycle. Push a byte -> tx_irq=0 until the stop bit ends, then 1 again.
